// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle 8x8 multiply (shift-and-add) and divide (repeated subtraction)
// sequencer that borrows the shared ULA one operation per clock.
module mdu_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       op,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] res_lo,
  output logic [7:0] res_hi,
  output logic       div_zero,
  output logic [7:0] ula_a,
  output logic [7:0] ula_b,
  output logic [2:0] ula_ctrl,
  input  logic [7:0] ula_out,
  input  logic       ula_zero
);
  localparam logic [2:0] ULA_ADD = 3'd0;
  localparam logic [2:0] ULA_SUB = 3'd1;
  localparam logic [2:0] ULA_SLT = 3'd4;
  localparam logic [2:0] ULA_SLL = 3'd5;
  localparam logic [2:0] ULA_SRL = 3'd6;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_M_ADD = 3'd1;
  localparam logic [2:0] S_M_SLL = 3'd2;
  localparam logic [2:0] S_M_SRL = 3'd3;
  localparam logic [2:0] S_D_SLT = 3'd4;
  localparam logic [2:0] S_D_SUB = 3'd5;
  localparam logic [2:0] S_D_INC = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;
  logic [2:0] r_state;
  logic [7:0] r_acc;
  logic [7:0] r_x;
  logic [7:0] r_y;
  logic       r_op;
  logic       r_dz;
  logic [2:0] w_next;
  logic       w_bz;
  assign w_bz = b_in == 8'd0;
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = !start ? S_IDLE : w_bz ? S_DONE : op ? S_D_SLT : b_in[0] ? S_M_ADD : S_M_SLL;
      S_M_ADD: w_next = S_M_SLL;
      S_M_SLL: w_next = S_M_SRL;
      S_M_SRL: w_next = ula_zero ? S_DONE : ula_out[0] ? S_M_ADD : S_M_SLL;
      S_D_SLT: w_next = ula_out[0] ? S_DONE : S_D_SUB;
      S_D_SUB: w_next = S_D_INC;
      S_D_INC: w_next = S_D_SLT;
      default: w_next = S_IDLE;
    endcase
  end
  // ULA operands are pure Moore decode; IDLE/DONE park on 0+0
  always_comb begin
    ula_a    = 8'd0;
    ula_b    = 8'd0;
    ula_ctrl = ULA_ADD;
    case (r_state)
      S_M_ADD: begin ula_a = r_acc; ula_b = r_x; end
      S_M_SLL: begin ula_a = r_x; ula_b = 8'd1; ula_ctrl = ULA_SLL; end
      S_M_SRL: begin ula_a = r_y; ula_b = 8'd1; ula_ctrl = ULA_SRL; end
      S_D_SLT: begin ula_a = r_x; ula_b = r_y; ula_ctrl = ULA_SLT; end
      S_D_SUB: begin ula_a = r_x; ula_b = r_y; ula_ctrl = ULA_SUB; end
      S_D_INC: begin ula_a = r_acc; ula_b = 8'd1; end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= 8'd0;
      r_x     <= 8'd0;
      r_y     <= 8'd0;
      r_op    <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (start) begin
          r_op  <= op;
          r_x   <= a_in;
          r_y   <= b_in;
          r_acc <= (op && w_bz) ? 8'hFF : 8'd0;
          r_dz  <= op && w_bz;
        end
        S_M_ADD, S_D_INC: r_acc <= ula_out;
        S_M_SLL, S_D_SUB: r_x <= ula_out;
        S_M_SRL: r_y <= ula_out;
        default: ;
      endcase
    end
  end
  assign busy     = r_state != S_IDLE;
  assign done     = r_state == S_DONE;
  assign res_lo   = r_acc;
  assign res_hi   = r_op ? r_x : 8'd0;
  assign div_zero = r_dz;
endmodule
